// File: rtl/kernel_bc_start_arb_pkg.sv
// Shared types and constants for the kernel_bc start-token round-robin arbiter.
package kernel_bc_start_arb_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_START = 1'b1
  } state_t;

  localparam int N_REQ_DEFAULT = 4;
  localparam int GRANT_W       = $clog2(N_REQ_DEFAULT);
  localparam int STAT_W        = 16;

  // Index width for a requester count; a lone requester still needs one bit.
  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/kernel_bc_rr_pick.sv
// Combinational round-robin picker: first set request after the last grant, wrapping.
module kernel_bc_rr_pick
  import kernel_bc_start_arb_pkg::*;
#(
  parameter int N  = N_REQ_DEFAULT,
  parameter int GW = GRANT_W
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last,
  output logic          vld,
  output logic [GW-1:0] win
);

  logic [GW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest hit is the one kept.
  always_comb begin
    vld = 1'b0;
    win = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = GW'((int'(last) + k) % N);
      if (req[idx]) begin
        vld = 1'b1;
        win = idx;
      end
    end
  end

endmodule

// File: rtl/kernel_bc_start_arbiter.sv
// Round-robin start-token arbiter sharing one downstream dataflow process among N_REQ start FIFOs.
// Optional per-requester grant and stall statistics under KERNEL_BC_START_ARB_STATS_EN.
module kernel_bc_start_arbiter
  import kernel_bc_start_arb_pkg::*;
#(
  parameter int N_REQ        = N_REQ_DEFAULT,
  parameter int DATA_WIDTH   = 1,
  parameter int MAX_INFLIGHT = 2,
  parameter int CNT_WIDTH    = 3,
  localparam int GID_W       = grant_width(N_REQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_empty_n,
  output logic [N_REQ-1:0]            req_read,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_dout,
  output logic                        ap_start,
  input  logic                        ap_ready,
  input  logic                        ap_done,
  output logic [DATA_WIDTH-1:0]       ap_token,
  output logic [GID_W-1:0]            grant_id,
  output logic [CNT_WIDTH-1:0]        inflight,
  output logic                        err_underflow,
  output logic                        idle
`ifdef KERNEL_BC_START_ARB_STATS_EN
  ,
  output logic [N_REQ*STAT_W-1:0]     stat_grants,
  output logic [STAT_W-1:0]           stat_stall_cycles
`endif
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_INFLIGHT);

  state_t                  state, state_nxt;
  logic                    pick_vld;
  logic [GID_W-1:0]        pick_win;
  logic                    at_limit;
  logic                    grant;
  logic                    started;
  logic [DATA_WIDTH-1:0]   tok_sel;

  kernel_bc_rr_pick #(
    .N  (N_REQ),
    .GW (GID_W)
  ) u_pick (
    .req  (req_empty_n),
    .last (grant_id),
    .vld  (pick_vld),
    .win  (pick_win)
  );

  assign at_limit = (inflight >= MAX_CNT);
  assign grant    = (state == S_IDLE) && pick_vld && !at_limit;
  assign started  = (state == S_START) && ap_ready;
  assign ap_start = (state == S_START);
  assign idle     = (state == S_IDLE) && (inflight == '0);

  always_comb begin
    tok_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_win == GID_W'(i)) tok_sel = req_dout[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_nxt = state;
    req_read  = '0;
    case (state)
      S_IDLE: begin
        if (grant) begin
          req_read[pick_win] = 1'b1;
          state_nxt          = S_START;
        end
      end
      S_START: begin
        if (ap_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ap_token <= '0;
      grant_id <= GID_W'(N_REQ - 1);
    end else begin
      state <= state_nxt;
      if (grant) begin
        ap_token <= tok_sel;
        grant_id <= pick_win;
      end
    end
  end

  // A start and a done in the same cycle cancel; a lone done at zero is a protocol error.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight      <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (started && !ap_done) begin
        inflight <= inflight + 1'b1;
      end else if (ap_done && !started) begin
        if (inflight == '0) err_underflow <= 1'b1;
        else                inflight      <= inflight - 1'b1;
      end
    end
  end

`ifdef KERNEL_BC_START_ARB_STATS_EN
  for (genvar i = 0; i < N_REQ; i++) begin : g_stat
    logic [STAT_W-1:0] cnt;
    always_ff @(posedge clk) begin
      if (reset)                          cnt <= '0;
      else if (req_read[i] && (~&cnt))    cnt <= cnt + 1'b1;
    end
    assign stat_grants[i*STAT_W +: STAT_W] = cnt;
  end

  always_ff @(posedge clk) begin
    if (reset)
      stat_stall_cycles <= '0;
    else if ((state == S_IDLE) && (|req_empty_n) && (inflight == MAX_CNT) && (~&stat_stall_cycles))
      stat_stall_cycles <= stat_stall_cycles + 1'b1;
  end
`endif

endmodule

// File: tb/tb_kernel_bc_start_arbiter.sv
// Scoreboard bench for kernel_bc_start_arbiter: expected grants queued at drive time, checked on each ap_start rise.
module tb_kernel_bc_start_arbiter;

  localparam int NR = 4;
  localparam int DW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_empty_n;
  logic [NR-1:0]   req_read;
  logic [NR*DW-1:0] req_dout;
  logic            ap_start, ap_ready, ap_done;
  logic [DW-1:0]   ap_token;
  logic [1:0]      grant_id;
  logic [2:0]      inflight;
  logic            err_underflow, idle;
`ifdef KERNEL_BC_START_ARB_STATS_EN
  logic [NR*16-1:0] stat_grants;
  logic [15:0]      stat_stall_cycles;
`endif

  kernel_bc_start_arbiter #(
    .N_REQ(NR), .DATA_WIDTH(DW), .MAX_INFLIGHT(2), .CNT_WIDTH(3)
  ) dut (
    .clk(clk), .reset(reset), .req_empty_n(req_empty_n), .req_read(req_read),
    .req_dout(req_dout), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .ap_token(ap_token), .grant_id(grant_id), .inflight(inflight),
    .err_underflow(err_underflow), .idle(idle)
`ifdef KERNEL_BC_START_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] gid; logic [3:0] tok; } exp_t;
  exp_t sbq[$];
  logic [3:0] tok_tbl [NR] = '{4'h1, 4'h3, 4'h5, 4'h7};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic samp;
    @(negedge clk);
  endtask

  task automatic push(input int g);
    exp_t e;
    e.gid = 2'(g);
    e.tok = tok_tbl[g];
    sbq.push_back(e);
  endtask

  task automatic do_reset;
    tick;
    reset = 1'b1; ap_done = 1'b0; req_empty_n = '0; ap_ready = 1'b0;
    tick; tick;
    reset = 1'b0;
  endtask

  // Protocol monitor and scoreboard pop on every ap_start rising edge.
  logic [NR-1:0] prev_read  = '0;
  logic          prev_start = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    chk("rd_onehot", 32'($onehot0(req_read)), 32'd1);
    chk("rd_guard", 32'(req_read & ~req_empty_n), 32'd0);
    chk("rd_b2b", 32'(req_read & prev_read), 32'd0);
    if (ap_start && !prev_start) begin
      chk("sb_pending", 32'(sbq.size() > 0), 32'd1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_gid", 32'(grant_id), 32'(e.gid));
        chk("sb_tok", 32'(ap_token), 32'(e.tok));
      end
    end
    prev_read  <= req_read;
    prev_start <= ap_start;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_empty_n = '0; ap_ready = 1'b0; ap_done = 1'b0;
    req_dout = {tok_tbl[3], tok_tbl[2], tok_tbl[1], tok_tbl[0]};
    tick; tick; samp;
    chk("rst_start", 32'(ap_start), 32'd0);
    chk("rst_token", 32'(ap_token), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd3);
    chk("rst_infl", 32'(inflight), 32'd0);
    chk("rst_err", 32'(err_underflow), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_read", 32'(req_read), 32'd0);

    // Single request: pop at cycle 0, start at 1, counted at 2.
    tick;
    reset = 1'b0; req_empty_n = 4'b0001; ap_ready = 1'b1; push(0);
    samp; chk("t1_read", 32'(req_read), 32'b0001);
    tick; req_empty_n = '0;
    samp; chk("t1_start", 32'(ap_start), 32'd1); chk("t1_tok", 32'(ap_token), 32'h1);
    tick;
    samp; chk("t1_infl", 32'(inflight), 32'd1); chk("t1_start_lo", 32'(ap_start), 32'd0);
    tick; ap_done = 1'b1;
    tick; ap_done = 1'b0;
    samp; chk("t1_infl_dn", 32'(inflight), 32'd0);

    // All requesters busy, one done per start: order 0,1,2,3,0.
    do_reset;
    req_empty_n = 4'hF; ap_ready = 1'b1;
    push(0); push(1); push(2); push(3); push(0);
    for (int c = 0; c < 10; c++) begin
      ap_done = (c % 2 == 0) && (c > 0);
      tick;
    end
    req_empty_n = '0; ap_done = 1'b0;
    samp;
    chk("t2_infl", 32'(inflight), 32'd1);
    chk("t2_err", 32'(err_underflow), 32'd0);
    chk("t2_gid", 32'(grant_id), 32'd0);

    // No done: grants stall at the in-flight limit, resume one cycle after a done.
    do_reset;
    req_empty_n = 4'hF; ap_ready = 1'b1;
    push(0); push(1);
    for (int c = 0; c < 4; c++) tick;
    for (int c = 0; c < 4; c++) begin
      samp;
      chk("t3_blk_read", 32'(req_read), 32'd0);
      chk("t3_blk_infl", 32'(inflight), 32'd2);
      tick;
    end
    ap_done = 1'b1;
    samp; chk("t3_done_read", 32'(req_read), 32'd0);
    tick; ap_done = 1'b0;
    samp;
    chk("t3_infl1", 32'(inflight), 32'd1);
    chk("t3_regrant", 32'(req_read), 32'b0100);
    push(2);
    tick; req_empty_n = '0;
    samp; chk("t3_start", 32'(ap_start), 32'd1);
    tick;
    samp; chk("t3_infl2", 32'(inflight), 32'd2);

    // Stalled handshake, then done coincident with ready.
    do_reset;
    req_empty_n = 4'b0010; ap_ready = 1'b1; push(1);
    tick; req_empty_n = '0;
    tick; ap_ready = 1'b0; req_empty_n = 4'b0100; push(2);
    samp; chk("t4_read", 32'(req_read), 32'b0100); chk("t4_infl0", 32'(inflight), 32'd1);
    tick; req_empty_n = '0;
    for (int k = 0; k < 5; k++) begin
      samp;
      chk("t4_hold_start", 32'(ap_start), 32'd1);
      chk("t4_hold_tok", 32'(ap_token), 32'h5);
      chk("t4_hold_read", 32'(req_read), 32'd0);
      chk("t4_hold_infl", 32'(inflight), 32'd1);
      tick;
    end
    ap_ready = 1'b1; ap_done = 1'b1;
    samp; chk("t4_last_start", 32'(ap_start), 32'd1);
    tick; ap_ready = 1'b0; ap_done = 1'b0;
    samp;
    chk("t4_start_lo", 32'(ap_start), 32'd0);
    chk("t4_infl_same", 32'(inflight), 32'd1);

    // Underflow is sticky; reset during a start clears everything.
    ap_done = 1'b1;
    tick; tick; ap_done = 1'b0;
    samp;
    chk("t5_err", 32'(err_underflow), 32'd1);
    chk("t5_infl0", 32'(inflight), 32'd0);
    tick; tick;
    samp;
    chk("t5_err_sticky", 32'(err_underflow), 32'd1);
    chk("t5_idle", 32'(idle), 32'd1);
    req_empty_n = 4'b0001; push(0);
    tick; req_empty_n = '0; reset = 1'b1;
    samp; chk("t5_in_start", 32'(ap_start), 32'd1);
    tick; reset = 1'b0;
    samp;
    chk("t5_rst_start", 32'(ap_start), 32'd0);
    chk("t5_rst_infl", 32'(inflight), 32'd0);
    chk("t5_rst_err", 32'(err_underflow), 32'd0);

`ifdef KERNEL_BC_START_ARB_STATS_EN
    do_reset;
    req_empty_n = 4'b0100; ap_ready = 1'b1;
    for (int g = 0; g < 10; g++) push(2);
    for (int c = 0; c < 20; c++) begin
      ap_done = (c % 2 == 0) && (c > 0);
      tick;
    end
    req_empty_n = '0; ap_done = 1'b0;
    samp;
    chk("st_grants10", 32'(stat_grants[2*16 +: 16]), 32'd10);
    chk("st_stall0", 32'(stat_stall_cycles), 32'd0);
    tick;
    req_empty_n = 4'b0100; push(2);
    for (int c = 0; c < 5; c++) tick;
    req_empty_n = '0;
    samp;
    chk("st_grants11", 32'(stat_grants[2*16 +: 16]), 32'd11);
    chk("st_stall3", 32'(stat_stall_cycles), 32'd3);
    chk("st_other", 32'(stat_grants[0 +: 16]), 32'd0);
`endif

    tick; tick;
    samp;
    chk("sb_left", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
